// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory port arbiter.
package imem_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0400_0000;

  typedef enum logic {IDLE, WRITE} state_t;

  typedef logic [1:0] byte_idx_t;

  // Big-endian byte select: index 0 is the most significant byte.
  function automatic logic [7:0] be_byte(input logic [31:0] word, input byte_idx_t k);
    logic [7:0] b;
    case (k)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/imem_port_arbiter.sv
// Shares a single-port byte memory between combinational fetch reads and
// loader word writes that are serialised into four byte writes.
//
// Handshake: the loader's word is taken on a rising edge where ld_valid and
// ld_ready are both high; ld_ready does not depend on ld_valid, and a word
// offered without ld_ready leaves no state behind.
module imem_port_arbiter
  import imem_pkg::*;
#(
  parameter logic [31:0] NOP   = NOP_INSTR,
  parameter int          CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_req,
  input  logic [31:0]      fetch_addr,
  output logic [31:0]      fetch_instr,
  output logic             fetch_valid,
  input  logic             ld_valid,
  input  logic [31:0]      ld_addr,
  input  logic [31:0]      ld_data,
  output logic             ld_ready,
  output logic [31:0]      mem_addr,
  output logic [7:0]       mem_wdata,
  output logic             mem_we,
  input  logic [31:0]      mem_rdata,
  output logic             busy,
  output logic [CNT_W-1:0] ld_count,
  output logic             ld_misaligned
);

  state_t      state;
  byte_idx_t   k;
  logic [31:0] base;
  logic [31:0] data;
  logic        fetch_owed;
  logic        accept;

  always_comb begin
    fetch_instr = NOP;
    fetch_valid = 1'b0;
    ld_ready    = 1'b0;
    mem_addr    = fetch_addr;
    mem_wdata   = 8'h00;
    mem_we      = 1'b0;
    busy        = 1'b0;
    if (state == IDLE) begin
      // The fetch stays on the port even in an accept cycle; writing starts next cycle.
      ld_ready    = !(fetch_owed && fetch_req);
      fetch_instr = mem_rdata;
      fetch_valid = fetch_req;
    end else begin
      mem_addr  = base + {30'd0, k};
      mem_wdata = be_byte(data, k);
      mem_we    = 1'b1;
      busy      = 1'b1;
    end
  end

  assign accept = (state == IDLE) && ld_valid && ld_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      k             <= 2'd0;
      base          <= 32'd0;
      data          <= 32'd0;
      fetch_owed    <= 1'b0;
      ld_count      <= '0;
      ld_misaligned <= 1'b0;
    end else if (state == IDLE) begin
      if (accept) begin
        data       <= ld_data;
        base       <= {ld_addr[31:2], 2'b00};
        k          <= 2'd0;
        state      <= WRITE;
        fetch_owed <= 1'b0;
        if (ld_addr[1:0] != 2'b00) ld_misaligned <= 1'b1;
      end else if (fetch_req) begin
        fetch_owed <= 1'b0;
      end
    end else begin
      k <= k + 2'd1;
      if (k == 2'd3) begin
        state      <= IDLE;
        fetch_owed <= 1'b1;
        if (ld_count != '1) ld_count <= ld_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a small byte-memory model.
module tb_imem_port_arbiter;
  import imem_pkg::*;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             fetch_req;
  logic [31:0]      fetch_addr;
  logic [31:0]      fetch_instr;
  logic             fetch_valid;
  logic             ld_valid;
  logic [31:0]      ld_addr;
  logic [31:0]      ld_data;
  logic             ld_ready;
  logic [31:0]      mem_addr;
  logic [7:0]       mem_wdata;
  logic             mem_we;
  logic [31:0]      mem_rdata;
  logic             busy;
  logic [CNT_W-1:0] ld_count;
  logic             ld_misaligned;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Observed writes of the last run_word call.
  logic        acc_ready;
  logic [31:0] obs_addr [4];
  logic [7:0]  obs_data [4];
  logic        obs_we   [4];
  logic        obs_fv   [4];
  logic [31:0] obs_fi   [4];

  imem_port_arbiter #(.NOP(32'h0400_0000), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_instr(fetch_instr), .fetch_valid(fetch_valid),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .busy(busy), .ld_count(ld_count), .ld_misaligned(ld_misaligned)
  );

  // ---------------- clock / reset / memory model ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running required finished");
    $fatal(1);
  end

  logic [7:0] mem [512];
  logic       clr;
  logic       pre_we;
  logic [8:0] pre_addr;
  logic [7:0] pre_data;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
    end else if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end
    if (mem_we) mem[mem_addr[8:0]] <= mem_wdata;
  end

  assign mem_rdata = {mem[mem_addr[8:0]], mem[mem_addr[8:0] + 9'd1],
                      mem[mem_addr[8:0] + 9'd2], mem[mem_addr[8:0] + 9'd3]};

  // ---------------- driver tasks ----------------
  task automatic preload_word(input logic [8:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pre_we   = 1'b1;
      pre_addr = a + 9'(i);
      pre_data = w[31 - 8*i -: 8];
    end
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Offers one word with no fetch traffic and records the four write cycles.
  task automatic run_word(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    fetch_req = 1'b0;
    ld_valid  = 1'b1;
    ld_addr   = a;
    ld_data   = d;
    #1 acc_ready = ld_ready;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ld_valid = 1'b0;
      #1;
      obs_addr[i] = mem_addr;
      obs_data[i] = mem_wdata;
      obs_we[i]   = mem_we;
      obs_fv[i]   = fetch_valid;
      obs_fi[i]   = fetch_instr;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; clr = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    fetch_req = 1'b0; fetch_addr = '0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    @(negedge clk);
    clr = 1'b0;
    preload_word(9'h010, 32'h8C01_0004);
    vec_cnt++; if (ld_count !== 16'd0) begin err_cnt++; $display("FAIL reset_count: got %h required 0", ld_count); end
    vec_cnt++; if (ld_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_ready: got %b required 1", ld_ready); end
    vec_cnt++; if (mem_we !== 1'b0) begin err_cnt++; $display("FAIL reset_we: got %b required 0", mem_we); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b required 0", busy); end
    vec_cnt++; if (ld_misaligned !== 1'b0) begin err_cnt++; $display("FAIL reset_misal: got %b required 0", ld_misaligned); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = 32'h10;
    #1;
    vec_cnt++; if (fetch_instr !== 32'h8C01_0004) begin err_cnt++; $display("FAIL fetch_instr: got %h required 8c010004", fetch_instr); end
    vec_cnt++; if (fetch_valid !== 1'b1) begin err_cnt++; $display("FAIL fetch_valid: got %b required 1", fetch_valid); end
    vec_cnt++; if (mem_addr !== 32'h10) begin err_cnt++; $display("FAIL fetch_addr: got %h required 00000010", mem_addr); end
  endtask

  task automatic test_load();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'h20; exp_b[1] = 8'h01; exp_b[2] = 8'h00; exp_b[3] = 8'h05;
    run_word(32'h20, 32'h2001_0005);
    vec_cnt++; if (acc_ready !== 1'b1) begin err_cnt++; $display("FAIL load_ready: got %b required 1", acc_ready); end
    for (int i = 0; i < 4; i++) begin
      vec_cnt++;
      if (obs_we[i] !== 1'b1 || obs_addr[i] !== 32'h20 + 32'(i) || obs_data[i] !== exp_b[i]) begin
        err_cnt++;
        $display("FAIL load_byte%0d: got we=%b addr=%h data=%h required we=1 addr=%h data=%h",
                 i, obs_we[i], obs_addr[i], obs_data[i], 32'h20 + 32'(i), exp_b[i]);
      end
    end
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = 32'h20;
    #1;
    vec_cnt++; if (fetch_instr !== 32'h2001_0005) begin err_cnt++; $display("FAIL load_readback: got %h required 20010005", fetch_instr); end
    vec_cnt++; if (ld_count !== 16'd1) begin err_cnt++; $display("FAIL load_count: got %0d required 1", ld_count); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL load_busy: got %b required 0", busy); end
  endtask

  task automatic test_back_to_back();
    // Word A accepted while fetch is also serviced.
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = 32'h40;
    ld_valid = 1'b1; ld_addr = 32'h40; ld_data = 32'h1122_3344;
    #1;
    vec_cnt++; if (ld_ready !== 1'b1 || fetch_valid !== 1'b1) begin err_cnt++; $display("FAIL b2b_accept: got ready=%b fv=%b required ready=1 fv=1", ld_ready, fetch_valid); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ld_addr = 32'h44; ld_data = 32'h5566_7788;
      #1;
      vec_cnt++;
      if (fetch_valid !== 1'b0 || fetch_instr !== 32'h0400_0000 || ld_ready !== 1'b0 || busy !== 1'b1) begin
        err_cnt++;
        $display("FAIL b2b_hold%0d: got fv=%b fi=%h ready=%b busy=%b required fv=0 fi=04000000 ready=0 busy=1",
                 i, fetch_valid, fetch_instr, ld_ready, busy);
      end
    end
    @(negedge clk);
    #1;
    vec_cnt++;
    if (ld_ready !== 1'b0 || fetch_valid !== 1'b1 || fetch_instr !== 32'h1122_3344) begin
      err_cnt++;
      $display("FAIL b2b_owed: got ready=%b fv=%b fi=%h required ready=0 fv=1 fi=11223344", ld_ready, fetch_valid, fetch_instr);
    end
    @(negedge clk);
    #1;
    vec_cnt++; if (ld_ready !== 1'b1) begin err_cnt++; $display("FAIL b2b_second_ready: got %b required 1", ld_ready); end
    @(negedge clk);
    ld_valid = 1'b0;
    #1;
    vec_cnt++; if (mem_we !== 1'b1 || mem_addr !== 32'h44 || mem_wdata !== 8'h55) begin
      err_cnt++;
      $display("FAIL b2b_second_write: got we=%b addr=%h data=%h required we=1 addr=00000044 data=55", mem_we, mem_addr, mem_wdata);
    end
    repeat (4) @(negedge clk);
    fetch_addr = 32'h44;
    #1;
    vec_cnt++; if (fetch_instr !== 32'h5566_7788 || ld_count !== 16'd3) begin
      err_cnt++;
      $display("FAIL b2b_done: got fi=%h count=%0d required fi=55667788 count=3", fetch_instr, ld_count);
    end
  endtask

  task automatic test_misaligned();
    run_word(32'h0000_0102, 32'hA1B2_C3D4);
    vec_cnt++;
    if (obs_addr[0] !== 32'h100 || obs_addr[3] !== 32'h103 || obs_data[0] !== 8'hA1 || obs_data[3] !== 8'hD4) begin
      err_cnt++;
      $display("FAIL misal_addr: got %h..%h data %h..%h required 00000100..00000103 data a1..d4",
               obs_addr[0], obs_addr[3], obs_data[0], obs_data[3]);
    end
    @(negedge clk);
    #1;
    vec_cnt++; if (ld_misaligned !== 1'b1) begin err_cnt++; $display("FAIL misal_flag: got %b required 1", ld_misaligned); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'hDE; exp_b[1] = 8'hAD; exp_b[2] = 8'hBE; exp_b[3] = 8'hEF;
    run_word(32'hFFFF_FFFC, 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) begin
      vec_cnt++;
      if (obs_addr[i] !== 32'hFFFF_FFFC + 32'(i) || obs_data[i] !== exp_b[i] || obs_fv[i] !== 1'b0 || obs_fi[i] !== 32'h0400_0000) begin
        err_cnt++;
        $display("FAIL wrap_byte%0d: got addr=%h data=%h fv=%b fi=%h required addr=%h data=%h fv=0 fi=04000000",
                 i, obs_addr[i], obs_data[i], obs_fv[i], obs_fi[i], 32'hFFFF_FFFC + 32'(i), exp_b[i]);
      end
    end
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = 32'hFFFF_FFFC;
    #1;
    vec_cnt++; if (fetch_instr !== 32'hDEAD_BEEF) begin err_cnt++; $display("FAIL wrap_readback: got %h required deadbeef", fetch_instr); end
    vec_cnt++; if (ld_count !== 16'd5 || ld_misaligned !== 1'b1) begin
      err_cnt++;
      $display("FAIL wrap_count: got count=%0d misal=%b required count=5 misal=1", ld_count, ld_misaligned);
    end
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk);
    fetch_req = 1'b0;
    ld_valid = 1'b1; ld_addr = 32'h80; ld_data = 32'hCAFE_F00D;
    @(negedge clk);
    ld_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    vec_cnt++; if (mem_we !== 1'b1 || mem_addr !== 32'h82) begin err_cnt++; $display("FAIL rstw_pre: got we=%b addr=%h required we=1 addr=00000082", mem_we, mem_addr); end
    rst = 1'b1;
    #1;
    vec_cnt++; if (mem_we !== 1'b0 || busy !== 1'b0 || ld_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL rstw_async: got we=%b busy=%b ready=%b required we=0 busy=0 ready=1", mem_we, busy, ld_ready);
    end
    vec_cnt++; if (ld_count !== 16'd0 || ld_misaligned !== 1'b0) begin
      err_cnt++;
      $display("FAIL rstw_regs: got count=%0d misal=%b required count=0 misal=0", ld_count, ld_misaligned);
    end
    @(negedge clk);
    rst = 1'b0;
    fetch_req = 1'b1; fetch_addr = 32'h80;
    #1;
    vec_cnt++; if (fetch_instr !== 32'hCAFE_0000) begin err_cnt++; $display("FAIL rstw_partial: got %h required cafe0000", fetch_instr); end
    @(negedge clk);
    fetch_addr = 32'h20;
    #1;
    vec_cnt++; if (fetch_instr !== 32'h2001_0005 || fetch_valid !== 1'b1) begin
      err_cnt++;
      $display("FAIL rstw_keep: got fi=%h fv=%b required fi=20010005 fv=1", fetch_instr, fetch_valid);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_fetch();
    test_load();
    test_back_to_back();
    test_misaligned();
    test_wrap();
    test_reset_mid_write();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
